// File: rtl/mult_div_if.sv
// Handshake and result bundle between the control unit and the mult/div sequencer.
// The div0 flag is present only when DIV_ZERO_EXC_EN is defined.
interface mult_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op_div;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             hi_w;
    logic             lo_w;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
`ifdef DIV_ZERO_EXC_EN
    logic             div0;

    modport master (
        output start, op_div, a, b,
        input  busy, done, hi_w, lo_w, hi_out, lo_out, div0
    );

    modport slave (
        input  start, op_div, a, b,
        output busy, done, hi_w, lo_w, hi_out, lo_out, div0
    );
`else
    modport master (
        output start, op_div, a, b,
        input  busy, done, hi_w, lo_w, hi_out, lo_out
    );

    modport slave (
        input  start, op_div, a, b,
        output busy, done, hi_w, lo_w, hi_out, lo_out
    );
`endif
endinterface

// File: rtl/mult_div_seq.sv
// Iterative signed mult/div sequencer sharing one (WIDTH+1)-bit add/subtract
// datapath. Mult is shift-add on magnitudes, div is restoring division on
// magnitudes; signs are applied in a final fix-up step.
// Optional feature macro: DIV_ZERO_EXC_EN (divide-by-zero short-cut with div0 flag).
module mult_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    mult_div_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_WRITE
    } state_t;

    state_t state_reg, state_next;

    logic [CW-1:0]    counter_reg;
    logic             op_div_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] mag_reg;      // |a| for mult, |b| for div
    logic [WIDTH:0]   acc_hi_reg;   // one extra bit for the add carry / trial borrow
    logic [WIDTH-1:0] acc_lo_reg;   // multiplier bits (mult) or dividend/quotient bits (div)
    logic             neg_q_reg;    // product / quotient sign
    logic             neg_r_reg;    // remainder sign follows the dividend

    logic             busy_reg;
    logic             done_reg;
    logic             hi_w_reg;
    logic             lo_w_reg;
    logic [WIDTH-1:0] hi_out_reg;
    logic [WIDTH-1:0] lo_out_reg;
`ifdef DIV_ZERO_EXC_EN
    logic             div0_reg;
`endif

    logic             div_by_zero;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   add_a;
    logic [WIDTH:0]   add_b;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0] quo_s;
    logic [WIDTH-1:0] rem_s;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (bus.start) state_next = S_PREP;
            S_PREP: begin
                state_next = S_ITER;
`ifdef DIV_ZERO_EXC_EN
                if (op_div_reg && div_by_zero) state_next = S_WRITE;
`endif
            end
            S_ITER:  if (counter_reg == CW'(WIDTH - 1)) state_next = S_FIX;
            S_FIX:   state_next = S_WRITE;
            S_WRITE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Operand magnitudes; the most negative value maps to unsigned 2^(WIDTH-1)
    always_comb begin
        div_by_zero = (b_reg == '0);
        a_mag       = a_reg[WIDTH-1] ? -a_reg : a_reg;
        b_mag       = b_reg[WIDTH-1] ? -b_reg : b_reg;
    end

    // Shared adder: mult adds |a| when the low multiplier bit is set, div subtracts |b|
    // from the left-shifted partial remainder (a set top bit means the trial went negative)
    always_comb begin
        add_a   = op_div_reg ? {acc_hi_reg[WIDTH-1:0], acc_lo_reg[WIDTH-1]} : acc_hi_reg;
        add_b   = op_div_reg ? ~{1'b0, mag_reg}
                             : (acc_lo_reg[0] ? {1'b0, mag_reg} : '0);
        add_sum = add_a + add_b + {{WIDTH{1'b0}}, op_div_reg};
        if (op_div_reg) begin
            if (add_sum[WIDTH]) begin
                step_hi = add_a;
                step_lo = {acc_lo_reg[WIDTH-2:0], 1'b0};
            end else begin
                step_hi = add_sum;
                step_lo = {acc_lo_reg[WIDTH-2:0], 1'b1};
            end
        end else begin
            step_hi = {1'b0, add_sum[WIDTH:1]};
            step_lo = {add_sum[0], acc_lo_reg[WIDTH-1:1]};
        end
    end

    // Sign fix-up of the magnitude results
    always_comb begin
        prod   = {acc_hi_reg[WIDTH-1:0], acc_lo_reg};
        prod_s = neg_q_reg ? -prod : prod;
        quo_s  = neg_q_reg ? -acc_lo_reg : acc_lo_reg;
        rem_s  = neg_r_reg ? -acc_hi_reg[WIDTH-1:0] : acc_hi_reg[WIDTH-1:0];
        if (op_div_reg) begin
            fix_hi = rem_s;
            fix_lo = quo_s;
`ifndef DIV_ZERO_EXC_EN
            // Divide by zero: restoring division yields all-ones quotient; HI reports the raw dividend
            if (div_by_zero) begin
                fix_hi = a_reg;
                fix_lo = '1;
            end
`endif
        end else begin
            fix_hi = prod_s[2*WIDTH-1:WIDTH];
            fix_lo = prod_s[WIDTH-1:0];
        end
    end

    // Operand capture, initialisation and one iteration step per cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            counter_reg <= '0;
            op_div_reg  <= 1'b0;
            a_reg       <= '0;
            b_reg       <= '0;
            mag_reg     <= '0;
            acc_hi_reg  <= '0;
            acc_lo_reg  <= '0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        op_div_reg <= bus.op_div;
                        a_reg      <= bus.a;
                        b_reg      <= bus.b;
                    end
                end
                S_PREP: begin
                    counter_reg <= '0;
                    acc_hi_reg  <= '0;
                    mag_reg     <= op_div_reg ? b_mag : a_mag;
                    acc_lo_reg  <= op_div_reg ? a_mag : b_mag;
                    neg_q_reg   <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1];
                    neg_r_reg   <= a_reg[WIDTH-1];
                end
                S_ITER: begin
                    counter_reg <= counter_reg + CW'(1);
                    acc_hi_reg  <= step_hi;
                    acc_lo_reg  <= step_lo;
                end
                default: ;
            endcase
        end
    end

    // Registered status, strobes and results; results load only on the FIX->WRITE edge
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            hi_w_reg   <= 1'b0;
            lo_w_reg   <= 1'b0;
            hi_out_reg <= '0;
            lo_out_reg <= '0;
`ifdef DIV_ZERO_EXC_EN
            div0_reg   <= 1'b0;
`endif
        end else begin
            busy_reg <= (state_next != S_IDLE);
            done_reg <= (state_next == S_WRITE);
            hi_w_reg <= (state_reg == S_FIX);
            lo_w_reg <= (state_reg == S_FIX);
`ifdef DIV_ZERO_EXC_EN
            div0_reg <= (state_reg == S_PREP) && (state_next == S_WRITE);
`endif
            if (state_reg == S_FIX) begin
                hi_out_reg <= fix_hi;
                lo_out_reg <= fix_lo;
            end
        end
    end

    assign bus.busy   = busy_reg;
    assign bus.done   = done_reg;
    assign bus.hi_w   = hi_w_reg;
    assign bus.lo_w   = lo_w_reg;
    assign bus.hi_out = hi_out_reg;
    assign bus.lo_out = lo_out_reg;
`ifdef DIV_ZERO_EXC_EN
    assign bus.div0   = div0_reg;
`endif

endmodule
